// File: rtl/encoder_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : encoder_mux_n
// Description : Time-interleaved priority-encoder result multiplexer. Latches
//               encoder result sets and reads them out on a per-encoder phase
//               slot with a runtime-programmable delay.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_mux_n #(
    parameter int               NUM_ENC      = 2,
    parameter int               NUM_CLUSTERS = 8,
    parameter int               ADR_W        = 11,
    parameter int               CNT_W        = 3,
    parameter int               BX_PHASES    = 4,
    parameter logic [ADR_W-1:0] INVALID_ADR  = 11'h7FE
) (
    input  logic                                    clock4x,
    input  logic                                    reset,
    input  logic                                    bx0_sync,
    input  logic [3:0]                              mux_dly_in,
    input  logic [NUM_ENC-1:0]                      enc_done_in,
    input  logic [NUM_ENC*NUM_CLUSTERS*ADR_W-1:0]   enc_adr_in,
    input  logic [NUM_ENC*NUM_CLUSTERS*CNT_W-1:0]   enc_cnt_in,
    output logic [NUM_ENC-1:0]                      latch_out,
    output logic [NUM_CLUSTERS*ADR_W-1:0]           adr_out,
    output logic [NUM_CLUSTERS*CNT_W-1:0]           cnt_out,
    output logic                                    valid_out,
    output logic [((NUM_ENC > 1) ? $clog2(NUM_ENC) : 1)-1:0] enc_sel_out,
    output logic [4:0]                              nclusters_out,
    output logic                                    overflow_out,
    output logic [7:0]                              missed_out
);

    localparam int c_FRAME = NUM_ENC * BX_PHASES;
    localparam int c_PH_W  = (c_FRAME > 1) ? $clog2(c_FRAME) : 1;
    localparam int c_SEL_W = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
    localparam int c_SET_A = NUM_CLUSTERS * ADR_W;
    localparam int c_SET_C = NUM_CLUSTERS * CNT_W;
    localparam logic [c_SET_A-1:0] c_EMPTY_SET = {NUM_CLUSTERS{INVALID_ADR}};

    logic [c_PH_W-1:0]  r_phase;
    logic [NUM_ENC-1:0] r_full;
    logic [c_SET_A-1:0] r_hold_adr [NUM_ENC];
    logic [c_SET_C-1:0] r_hold_cnt [NUM_ENC];

    logic [NUM_ENC-1:0] w_rd;
    logic [NUM_ENC-1:0] w_latch;
    logic               w_rd_any;
    logic               w_sel_full;
    logic               w_ovf_set;
    logic [c_SEL_W-1:0] w_rd_sel;
    logic [c_SET_A-1:0] w_sel_adr;
    logic [c_SET_C-1:0] w_sel_cnt;
    int                 w_dly_mod;

    function automatic logic [4:0] count_valid(input logic [c_SET_A-1:0] set);
        logic [4:0] n;
        n = '0;
        for (int k = 0; k < NUM_CLUSTERS; k++) begin
            if (set[k*ADR_W +: ADR_W] != INVALID_ADR) n = n + 5'd1;
        end
        return n;
    endfunction

    always_ff @(posedge clock4x or negedge reset) begin
        if (!reset) begin
            r_phase <= '0;
        end else if (bx0_sync) begin
            r_phase <= '0;
        end else if (int'(r_phase) == c_FRAME - 1) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign w_dly_mod = int'(mux_dly_in) % c_FRAME;

    generate
        for (genvar e = 0; e < NUM_ENC; e++) begin : g_enc
            localparam int c_BASE = e * BX_PHASES;
            assign w_latch[e] = (int'(r_phase) == c_BASE);
            assign w_rd[e]    = (int'(r_phase) == (c_BASE + w_dly_mod) % c_FRAME);
        end
    endgenerate

    // A fresh capture always leaves the slot full, even when it is read out
    // on the same edge (the read then sees the previous contents).
    always_ff @(posedge clock4x or negedge reset) begin
        if (!reset) begin
            r_full <= '0;
        end else begin
            for (int e = 0; e < NUM_ENC; e++) begin
                if (enc_done_in[e])  r_full[e] <= 1'b1;
                else if (w_rd[e])    r_full[e] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock4x) begin
        for (int e = 0; e < NUM_ENC; e++) begin
            if (enc_done_in[e]) begin
                r_hold_adr[e] <= enc_adr_in[e*c_SET_A +: c_SET_A];
                r_hold_cnt[e] <= enc_cnt_in[e*c_SET_C +: c_SET_C];
            end
        end
    end

    always_comb begin
        w_rd_any   = 1'b0;
        w_rd_sel   = '0;
        w_sel_full = 1'b0;
        w_sel_adr  = c_EMPTY_SET;
        w_sel_cnt  = '0;
        for (int e = 0; e < NUM_ENC; e++) begin
            if (w_rd[e]) begin
                w_rd_any   = 1'b1;
                w_rd_sel   = c_SEL_W'(e);
                w_sel_full = r_full[e];
                w_sel_adr  = r_hold_adr[e];
                w_sel_cnt  = r_hold_cnt[e];
            end
        end
    end

    assign w_ovf_set = |(enc_done_in & r_full & ~w_rd);

    always_ff @(posedge clock4x or negedge reset) begin
        if (!reset) begin
            latch_out     <= '0;
            adr_out       <= c_EMPTY_SET;
            cnt_out       <= '0;
            valid_out     <= 1'b0;
            enc_sel_out   <= '0;
            nclusters_out <= '0;
            overflow_out  <= 1'b0;
            missed_out    <= '0;
        end else begin
            latch_out <= w_latch;
            valid_out <= 1'b0;
            if (w_ovf_set) overflow_out <= 1'b1;
            if (w_rd_any) begin
                enc_sel_out <= w_rd_sel;
                if (w_sel_full) begin
                    adr_out       <= w_sel_adr;
                    cnt_out       <= w_sel_cnt;
                    valid_out     <= 1'b1;
                    nclusters_out <= count_valid(w_sel_adr);
                end else begin
                    adr_out       <= c_EMPTY_SET;
                    cnt_out       <= '0;
                    nclusters_out <= '0;
                    if (missed_out != 8'hFF) missed_out <= missed_out + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_encoder_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_mux_n
// Description : Self-checking bench for encoder_mux_n with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_mux_n;

    localparam int NE    = 2;
    localparam int NC    = 8;
    localparam int AW    = 11;
    localparam int CW    = 3;
    localparam int BX    = 4;
    localparam int FRAME = NE * BX;
    localparam logic [AW-1:0] INV = 11'h7FE;

    logic               clock4x;
    logic               reset;
    logic               bx0_sync;
    logic [3:0]         mux_dly_in;
    logic [NE-1:0]      enc_done_in;
    logic [NE*NC*AW-1:0] enc_adr_in;
    logic [NE*NC*CW-1:0] enc_cnt_in;
    logic [NE-1:0]      latch_out;
    logic [NC*AW-1:0]   adr_out;
    logic [NC*CW-1:0]   cnt_out;
    logic               valid_out;
    logic [0:0]         enc_sel_out;
    logic [4:0]         nclusters_out;
    logic               overflow_out;
    logic [7:0]         missed_out;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    encoder_mux_n dut (
        .clock4x(clock4x), .reset(reset), .bx0_sync(bx0_sync),
        .mux_dly_in(mux_dly_in), .enc_done_in(enc_done_in),
        .enc_adr_in(enc_adr_in), .enc_cnt_in(enc_cnt_in),
        .latch_out(latch_out), .adr_out(adr_out), .cnt_out(cnt_out),
        .valid_out(valid_out), .enc_sel_out(enc_sel_out),
        .nclusters_out(nclusters_out), .overflow_out(overflow_out),
        .missed_out(missed_out)
    );

    initial clock4x = 1'b0;
    always #5 clock4x = ~clock4x;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles elapsed since realign give the frame slot;
    // result sets are kept as plain arrays of cluster words.
    int              m_t, m_ph, m_rd, m_ncl, m_sel, m_missed;
    logic [NE-1:0]   m_latch, m_full;
    logic            m_valid, m_ovf;
    logic [AW-1:0]   m_hadr [NE][NC];
    logic [CW-1:0]   m_hcnt [NE][NC];
    logic [AW-1:0]   m_adr [NC];
    logic [CW-1:0]   m_cnt [NC];
    logic [NC*AW-1:0] m_adr_p;
    logic [NC*CW-1:0] m_cnt_p;

    always @(posedge clock4x or negedge reset) begin
        if (!reset) begin
            m_t = 0; m_latch = '0; m_full = '0; m_valid = 1'b0;
            m_sel = 0; m_ncl = 0; m_ovf = 1'b0; m_missed = 0;
            for (int k = 0; k < NC; k++) begin m_adr[k] = INV; m_cnt[k] = '0; end
        end else begin
            m_ph = m_t % FRAME;
            m_rd = -1;
            for (int e = 0; e < NE; e++) begin
                m_latch[e] = (m_ph == e * BX);
                if (m_ph == (e * BX + int'(mux_dly_in)) % FRAME) m_rd = e;
            end
            m_valid = 1'b0;
            if (m_rd >= 0) begin
                m_sel = m_rd;
                m_ncl = 0;
                if (m_full[m_rd]) begin
                    m_valid = 1'b1;
                    m_full[m_rd] = 1'b0;
                    for (int k = 0; k < NC; k++) begin
                        m_adr[k] = m_hadr[m_rd][k];
                        m_cnt[k] = m_hcnt[m_rd][k];
                        if (m_adr[k] != INV) m_ncl++;
                    end
                end else begin
                    for (int k = 0; k < NC; k++) begin m_adr[k] = INV; m_cnt[k] = '0; end
                    if (m_missed < 255) m_missed++;
                end
            end
            for (int e = 0; e < NE; e++) begin
                if (enc_done_in[e]) begin
                    if (m_full[e]) m_ovf = 1'b1;
                    m_full[e] = 1'b1;
                    for (int k = 0; k < NC; k++) begin
                        m_hadr[e][k] = enc_adr_in[(e*NC+k)*AW +: AW];
                        m_hcnt[e][k] = enc_cnt_in[(e*NC+k)*CW +: CW];
                    end
                end
            end
            m_t = bx0_sync ? 0 : m_t + 1;
        end
    end

    always @(negedge clock4x) begin
        if (chk_en) begin
            for (int k = 0; k < NC; k++) begin
                m_adr_p[k*AW +: AW] = m_adr[k];
                m_cnt_p[k*CW +: CW] = m_cnt[k];
            end
            check("model_latch", 128'(latch_out), 128'(m_latch));
            check("model_adr", 128'(adr_out), 128'(m_adr_p));
            check("model_cnt", 128'(cnt_out), 128'(m_cnt_p));
            check("model_valid", 128'(valid_out), 128'(m_valid));
            check("model_sel", 128'(enc_sel_out), 128'(m_sel));
            check("model_ncl", 128'(nclusters_out), 128'(m_ncl));
            check("model_ovf", 128'(overflow_out), 128'(m_ovf));
            check("model_missed", 128'(missed_out), 128'(m_missed));
        end
    end

    task automatic step();
        @(posedge clock4x);
        #1;
    endtask

    task automatic load_enc(input int e, input int n, input logic [AW-1:0] base, input logic [CW-1:0] c);
        for (int k = 0; k < NC; k++) begin
            enc_adr_in[(e*NC+k)*AW +: AW] = (k < n) ? base + AW'(k) : INV;
            enc_cnt_in[(e*NC+k)*CW +: CW] = (k < n) ? c : '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_latch"}, 128'(latch_out), 128'(0));
        check({tag, "_adr"}, 128'(adr_out), 128'({NC{INV}}));
        check({tag, "_cnt"}, 128'(cnt_out), 128'(0));
        check({tag, "_valid"}, 128'(valid_out), 128'(0));
        check({tag, "_sel"}, 128'(enc_sel_out), 128'(0));
        check({tag, "_ncl"}, 128'(nclusters_out), 128'(0));
        check({tag, "_ovf"}, 128'(overflow_out), 128'(0));
        check({tag, "_missed"}, 128'(missed_out), 128'(0));
    endtask

    typedef struct {
        int            enc;
        logic [3:0]    dly;
        int            n;
        logic [AW-1:0] adr;
        logic [CW-1:0] cnt;
        int            exp_wait;
        int            exp_ncl;
        logic [AW-1:0] exp_adr0;
        logic [CW-1:0] exp_cnt0;
    } vec_t;

    vec_t vecs [7];

    task automatic wait_valid(output int w);
        w = 0;
        while (w < 2 * FRAME) begin
            step();
            w++;
            if (valid_out) break;
        end
    endtask

    initial begin
        int w;
        vecs[0] = '{0, 4'd0,  1, 11'h010, 3'd2, 1, 1, 11'h010, 3'd2};
        vecs[1] = '{1, 4'd0,  8, 11'h100, 3'd5, 5, 8, 11'h100, 3'd5};
        vecs[2] = '{0, 4'd3,  3, 11'h020, 3'd1, 4, 3, 11'h020, 3'd1};
        vecs[3] = '{1, 4'd3,  0, 11'h030, 3'd7, 8, 0, 11'h7FE, 3'd0};
        vecs[4] = '{1, 4'd13, 5, 11'h040, 3'd3, 2, 5, 11'h040, 3'd3};
        vecs[5] = '{0, 4'd15, 2, 11'h050, 3'd4, 8, 2, 11'h050, 3'd4};
        vecs[6] = '{1, 4'd8,  7, 11'h060, 3'd6, 5, 7, 11'h060, 3'd6};

        reset = 1'b1; bx0_sync = 1'b0; mux_dly_in = 4'd0; enc_done_in = '0;
        enc_adr_in = {(NE*NC){INV}}; enc_cnt_in = '0;
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;
        #19;
        check_reset_outputs("rst");

        // Free run from release: latch pulses and missed slots.
        @(posedge clock4x); #3 reset = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            step();
            check("run_latch0", 128'(latch_out[0]), 128'((c % 8) == 1));
            check("run_latch1", 128'(latch_out[1]), 128'((c % 8) == 5));
            check("run_valid", 128'(valid_out), 128'(0));
        end
        check("run_missed", 128'(missed_out), 128'(8));
        check("run_adr", 128'(adr_out), 128'({NC{INV}}));

        for (int i = 0; i < 7; i++) begin
            load_enc(vecs[i].enc, vecs[i].n, vecs[i].adr, vecs[i].cnt);
            mux_dly_in  = vecs[i].dly;
            bx0_sync    = 1'b1;
            enc_done_in = NE'(1) << vecs[i].enc;
            step();
            bx0_sync = 1'b0; enc_done_in = '0;
            wait_valid(w);
            check("tbl_wait", 128'(w), 128'(vecs[i].exp_wait));
            check("tbl_sel", 128'(enc_sel_out), 128'(vecs[i].enc));
            check("tbl_ncl", 128'(nclusters_out), 128'(vecs[i].exp_ncl));
            check("tbl_adr0", 128'(adr_out[AW-1:0]), 128'(vecs[i].exp_adr0));
            check("tbl_cnt0", 128'(cnt_out[CW-1:0]), 128'(vecs[i].exp_cnt0));
        end

        // Two captures into encoder 1 with no readout between.
        mux_dly_in = 4'd0; bx0_sync = 1'b1;
        step();
        bx0_sync = 1'b0; load_enc(1, 2, 11'h111, 3'd1); enc_done_in = 2'b10;
        step();
        check("ovf_pre", 128'(overflow_out), 128'(0));
        load_enc(1, 3, 11'h222, 3'd2); enc_done_in = 2'b10;
        step();
        enc_done_in = '0;
        check("ovf_set", 128'(overflow_out), 128'(1));
        wait_valid(w);
        check("ovf_wait", 128'(w), 128'(3));
        check("ovf_sel", 128'(enc_sel_out), 128'(1));
        check("ovf_adr0", 128'(adr_out[AW-1:0]), 128'(11'h222));
        check("ovf_ncl", 128'(nclusters_out), 128'(3));

        // Realign in the middle of a frame.
        bx0_sync = 1'b1; step(); bx0_sync = 1'b0;
        step(); step(); step();
        bx0_sync = 1'b1; step(); bx0_sync = 1'b0;
        check("realign_l0_early", 128'(latch_out[0]), 128'(0));
        step();
        check("realign_l0", 128'(latch_out[0]), 128'(1));

        for (int i = 0; i < 800; i++) begin
            for (int e = 0; e < NE; e++) begin
                enc_done_in[e] = ($urandom_range(0, 4) == 0);
                for (int k = 0; k < NC; k++) begin
                    enc_adr_in[(e*NC+k)*AW +: AW] = ($urandom_range(0, 1) == 0) ? INV : AW'($urandom);
                    enc_cnt_in[(e*NC+k)*CW +: CW] = CW'($urandom);
                end
            end
            bx0_sync = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) mux_dly_in = 4'($urandom_range(0, 15));
            step();
        end

        // Reset while encoder 1 holds an unread result.
        enc_done_in = '0; mux_dly_in = 4'd0; bx0_sync = 1'b1;
        step();
        bx0_sync = 1'b0; load_enc(1, 4, 11'h333, 3'd3); enc_done_in = 2'b10;
        step();
        enc_done_in = '0;
        step();
        #2 reset = 1'b0;
        #1 check_reset_outputs("arst");
        #20 reset = 1'b1;
        for (int c = 0; c < 24; c++) begin
            step();
            check("post_rst_valid", 128'(valid_out), 128'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/encoder_mux_n.md
ENCODER_MUX_N -- requirements
Module: encoder_mux_n

Interface
REQ-001 Parameter NUM_ENC, default 2: number of time-interleaved priority encoders served (1..4).
REQ-002 Parameter NUM_CLUSTERS, default 8: clusters per encoder result set (1..16).
REQ-003 Parameter ADR_W, default 11: cluster address width.
REQ-004 Parameter CNT_W, default 3: cluster size-count width.
REQ-005 Parameter BX_PHASES, default 4: clock4x cycles per bunch crossing; FRAME = NUM_ENC*BX_PHASES.
REQ-006 Parameter INVALID_ADR, default 11'h7FE: address marking an empty cluster slot.
REQ-007 clock4x  input  1  160 MHz clock, sole clock; one clock, reset is asynchronous and active-low.
REQ-008 reset  input  1  asynchronous active-low reset (low = in reset).
REQ-009 bx0_sync  input  1  phase realign strobe.
REQ-010 mux_dly_in  input  4  runtime readout delay, clock4x cycles.
REQ-011 enc_done_in  input  NUM_ENC  per-encoder result-ready strobe.
REQ-012 enc_adr_in  input  NUM_ENC*NUM_CLUSTERS*ADR_W  encoder addresses, encoder e at slice e, cluster k inside it.
REQ-013 enc_cnt_in  input  NUM_ENC*NUM_CLUSTERS*CNT_W  encoder counts, same packing.
REQ-014 latch_out  output  NUM_ENC  per-encoder input-latch strobe.
REQ-015 adr_out  output  NUM_CLUSTERS*ADR_W  selected addresses.
REQ-016 cnt_out  output  NUM_CLUSTERS*CNT_W  selected counts.
REQ-017 valid_out  output  1  one-cycle pulse: fresh result set on adr_out/cnt_out.
REQ-018 enc_sel_out  output  clog2(NUM_ENC) (min 1)  encoder index currently driving outputs.
REQ-019 nclusters_out  output  5  number of slots in the current set with adr != INVALID_ADR.
REQ-020 overflow_out  output  1  sticky: result arrived while prior result unread.
REQ-021 missed_out  output  8  saturating count of readout slots with no result.

Function
REQ-022 Phase counter: clog2(FRAME) bits, increments each clock4x, wraps FRAME-1 -> 0; bx0_sync=1 loads 0 next edge (takes priority over increment).
REQ-023 latch_out[e] registered, high exactly one cycle, in the cycle after phase == e*BX_PHASES.
REQ-024 Per-encoder holding register (adr, cnt, full flag): enc_done_in[e]=1 captures slice e and sets full next edge.
REQ-025 Readout strobe for encoder e when phase == (e*BX_PHASES + mux_dly_in) mod FRAME; mux_dly_in >= FRAME reduced mod FRAME.
REQ-026 On readout strobe, next edge: enc_sel_out=e; if full[e]: adr/cnt_out = holding e, valid_out=1, full[e] cleared; else adr_out all INVALID_ADR, cnt_out 0, valid_out=0, missed_out +1 (saturate 255).
REQ-027 Outputs hold between strobes; valid_out high only the one cycle after strobe.
REQ-028 nclusters_out registered with adr_out, same cycle, computed from the set being loaded.
REQ-029 Simultaneous enc_done_in[e] and readout of e: the read takes the old contents if full, new data captured and full stays 1; if not full, read yields empty set (miss) and new data captured.
REQ-030 enc_done_in[e] while full[e] and not being read: new data overwrites, overflow_out set, stays set until reset.
REQ-031 Latency: enc_done to valid_out minimum 2 cycles (capture edge + readout edge).
REQ-032 mux_dly_in changes take effect on the next phase comparison; no other state disturbed.

Reset
REQ-033 reset low asynchronously clears: phase 0, latch_out 0, all full flags 0, adr_out all INVALID_ADR, cnt_out 0, valid_out 0, enc_sel_out 0, nclusters_out 0, overflow_out 0, missed_out 0.
REQ-034 After reset release, first latch_out[0] pulse occurs the cycle after first edge with phase 0, i.e. 1 cycle after release; reset mid-frame discards held results without valid_out.

Verification
REQ-035 Defaults, mux_dly_in=0, free run 16 cycles -> latch_out[0] pulses at cycles 1,9; latch_out[1] at 5,13.
REQ-036 enc_done_in[0] with adr0=0x010 cnt0=2, other slots 0x7FE, before phase 0 -> valid_out once, enc_sel_out=0, adr_out slot0=0x010, nclusters_out=1.
REQ-037 No enc_done for 4 frames -> valid_out never high, missed_out=8, adr_out all 0x7FE.
REQ-038 Two enc_done_in[1] pulses without a readout between -> overflow_out=1, later read returns second data.
REQ-039 mux_dly_in=3 -> readout of encoder 0 at phase 3, encoder 1 at phase 7; bx0_sync mid-frame -> next latch_out[0] one cycle after realign.
REQ-040 reset asserted while full[1]=1 -> all outputs at reset values immediately; no valid_out after release until new enc_done.
